// File: rtl/nt_mon_pkg.sv
// Shared types and helpers for the Nt-node activity monitor.
//   state_t  : monitor FSM states
//   result_t : one window's result record (counts zero-extended to RES_CNT_W)
//   cnt_w()  : counter width able to hold the value WINDOW
package nt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int unsigned RES_CNT_W = 32;

  typedef struct packed {
    logic [RES_CNT_W-1:0] toggle_count;
    logic [RES_CNT_W-1:0] ones_count;
    logic                 match_flag;
    logic                 rare_flag;
  } result_t;

  function automatic int unsigned cnt_w(input int unsigned window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/nt_pattern_matcher.sv
// Shift register plus masked pattern compare with a sticky per-window match bit.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : capture pattern/mask, empty the shift register, drop match
//   shift        : shift bit_in in at bit 0 (newest sample)
//   enable       : compare is meaningful (enough samples taken this window)
//   pattern      : target sequence, captured on clear
//   pat_mask     : 1 = bit compared, captured on clear
//   match        : sticky match flag for the current window
module nt_pattern_matcher #(
  parameter int unsigned PAT_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic               enable,
  input  logic               bit_in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN-1:0] pat_mask,
  output logic               match
);

  logic [PAT_LEN-1:0] shreg;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] mask_q;
  logic [PAT_LEN-1:0] shreg_next_c;
  logic               hit_c;

  // Compare against the post-shift value so the newest sample participates.
  generate
    if (PAT_LEN == 1) begin : g_one
      assign shreg_next_c = bit_in;
    end else begin : g_many
      assign shreg_next_c = {shreg[PAT_LEN-2:0], bit_in};
    end
  endgenerate

  assign hit_c = ((shreg_next_c ^ pat_q) & mask_q) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      pat_q  <= '0;
      mask_q <= '0;
      match  <= 1'b0;
    end else if (clear) begin
      shreg  <= '0;
      pat_q  <= pattern;
      mask_q <= pat_mask;
      match  <= 1'b0;
    end else if (shift) begin
      shreg <= shreg_next_c;
      if (enable && hit_c) match <= 1'b1;
    end
  end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Window-based activity monitor for one Nt-node net: counts toggles and ones
// over WINDOW enabled samples, detects a masked pattern and flags rare activity.
//   I1470        : clock
//   I1477        : synchronous active-high reset
//   start        : begin a window (IDLE only)
//   sample_en    : qualifies node_in
//   node_in      : monitored net
//   pattern      : target sequence (bit 0 newest), captured at start
//   pat_mask     : compare mask, captured at start
//   busy         : high in SAMPLE and REPORT
//   result_valid : result available, held until result_ready
//   result_ready : consumer accepts result
//   toggle_count : transitions between consecutive enabled samples
//   ones_count   : enabled samples equal to 1
//   match_flag   : masked pattern seen in the window
//   rare_flag    : rare-activity verdict
module nt_node_activity_monitor
  import nt_mon_pkg::*;
#(
  parameter  int unsigned WINDOW      = 256,
  parameter  int unsigned RARE_THRESH = 2,
  parameter  int unsigned PAT_LEN     = 8,
  localparam int unsigned CNT_W       = cnt_w(WINDOW)
) (
  input  logic               I1470,
  input  logic               I1477,
  input  logic               start,
  input  logic               sample_en,
  input  logic               node_in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN-1:0] pat_mask,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   toggle_count,
  output logic [CNT_W-1:0]   ones_count,
  output logic               match_flag,
  output logic               rare_flag
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             prev_q, prev_d;
  logic             rare_q, rare_d;
  logic             busy_q, valid_q;
  logic             clear_c, shift_c, arm_c;

  // State register.
  always_ff @(posedge I1470) begin
    if (I1477) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tog_d   = tog_q;
    ones_d  = ones_q;
    prev_d  = prev_q;
    rare_d  = rare_q;
    clear_c = 1'b0;
    shift_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          idx_d   = '0;
          tog_d   = '0;
          ones_d  = '0;
          prev_d  = 1'b0;
          rare_d  = 1'b0;
          clear_c = 1'b1;
        end
      end
      SAMPLE: begin
        if (sample_en) begin
          shift_c = 1'b1;
          ones_d  = ones_q + CNT_W'(node_in);
          if (idx_q != '0 && node_in != prev_q) tog_d = tog_q + CNT_W'(1);
          prev_d = node_in;
          idx_d  = idx_q + CNT_W'(1);
          // Last sample of the window: verdict uses the just-updated counts.
          if (idx_q == CNT_W'(WINDOW - 1)) begin
            state_d = REPORT;
            rare_d  = (32'(tog_d) < RARE_THRESH) || (ones_d == '0) ||
                      (32'(ones_d) == WINDOW);
          end
        end
      end
      REPORT: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Matcher compare is armed once this shift brings the count to PAT_LEN.
  assign arm_c = 32'(idx_q) >= PAT_LEN - 1;

  always_ff @(posedge I1470) begin
    if (I1477) begin
      idx_q   <= '0;
      tog_q   <= '0;
      ones_q  <= '0;
      prev_q  <= 1'b0;
      rare_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      tog_q   <= tog_d;
      ones_q  <= ones_d;
      prev_q  <= prev_d;
      rare_q  <= rare_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == REPORT);
    end
  end

  nt_pattern_matcher #(
    .PAT_LEN (PAT_LEN)
  ) u_matcher (
    .clk      (I1470),
    .rst      (I1477),
    .clear    (clear_c),
    .shift    (shift_c),
    .enable   (arm_c),
    .bit_in   (node_in),
    .pattern  (pattern),
    .pat_mask (pat_mask),
    .match    (match_flag)
  );

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign toggle_count = tog_q;
  assign ones_count   = ones_q;
  assign rare_flag    = rare_q;

  // Toggles are only counted between samples, so at most WINDOW-1.
  a_tog_bound : assert property (@(posedge I1470) disable iff (I1477)
    32'(tog_q) <= WINDOW - 1);

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Directed, table-driven bench for nt_node_activity_monitor (WINDOW=8, PAT_LEN=4).
module tb_nt_node_activity_monitor;
  import nt_mon_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned PL = 4;
  localparam int unsigned RT = 2;
  localparam int unsigned CW = cnt_w(W);
  localparam int unsigned NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_en;
  logic          node_in;
  logic [PL-1:0] pattern;
  logic [PL-1:0] pat_mask;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] toggle_count;
  logic [CW-1:0] ones_count;
  logic          match_flag;
  logic          rare_flag;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]    stream;   // bit 7 is applied first
    logic [PL-1:0] pat;
    logic [PL-1:0] mask;
    result_t       exp;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  nt_node_activity_monitor #(
    .WINDOW      (W),
    .RARE_THRESH (RT),
    .PAT_LEN     (PL)
  ) dut (
    .I1470        (clk),
    .I1477        (rst),
    .start        (start),
    .sample_en    (sample_en),
    .node_in      (node_in),
    .pattern      (pattern),
    .pat_mask     (pat_mask),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .toggle_count (toggle_count),
    .ones_count   (ones_count),
    .match_flag   (match_flag),
    .rare_flag    (rare_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input result_t e);
    chk({tag, ".toggle"}, 32'(toggle_count), e.toggle_count);
    chk({tag, ".ones"},   32'(ones_count),   e.ones_count);
    chk({tag, ".match"},  32'(match_flag),   32'(e.match_flag));
    chk({tag, ".rare"},   32'(rare_flag),    32'(e.rare_flag));
  endtask

  // Pulse start, feed 8 enabled samples, check valid latency.
  task automatic run_window(input string tag, input logic [7:0] s,
                            input logic [PL-1:0] p, input logic [PL-1:0] m);
    pattern  = p;
    pat_mask = m;
    start    = 1'b1;
    step();
    start    = 1'b0;
    pattern  = ~p;     // captured value must be used, not the live input
    pat_mask = ~m;
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      node_in   = s[7-i];
      if (i == 7) chk({tag, ".valid_early"}, 32'(result_valid), 32'd0);
      step();
    end
    sample_en = 1'b0;
    node_in   = 1'b0;
    chk({tag, ".valid"}, 32'(result_valid), 32'd1);
  endtask

  task automatic handshake(input string tag, input result_t e);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, ".valid_off"}, 32'(result_valid), 32'd0);
    chk({tag, ".busy_off"},  32'(busy),         32'd0);
    check_result({tag, ".kept"}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result_t e;

    vecs[0] = '{8'b10101010, 4'b0110, 4'b1111, '{32'd7, 32'd4, 1'b0, 1'b0}};
    vecs[1] = '{8'b11111111, 4'b0000, 4'b0000, '{32'd0, 32'd8, 1'b1, 1'b1}};
    vecs[2] = '{8'b00110000, 4'b0110, 4'b1111, '{32'd2, 32'd2, 1'b1, 1'b0}};
    vecs[3] = '{8'b00110000, 4'b1001, 4'b1111, '{32'd2, 32'd2, 1'b0, 1'b0}};
    vecs[4] = '{8'b00000000, 4'b0000, 4'b1111, '{32'd0, 32'd0, 1'b1, 1'b1}};
    vecs[5] = '{8'b10000000, 4'b1000, 4'b1000, '{32'd1, 32'd1, 1'b1, 1'b1}};
    vecs[6] = '{8'b01111111, 4'b0111, 4'b1111, '{32'd1, 32'd7, 1'b1, 1'b1}};
    vecs[7] = '{8'b11001100, 4'b0011, 4'b0011, '{32'd3, 32'd4, 1'b1, 1'b0}};
    vecs[8] = '{8'b11111111, 4'b0000, 4'b0001, '{32'd0, 32'd8, 1'b0, 1'b1}};
    // 0111 only appears before 4 samples are in, so it must not match.
    vecs[9] = '{8'b11100000, 4'b0111, 4'b0111, '{32'd1, 32'd3, 1'b0, 1'b1}};

    rst = 1'b1; start = 1'b1; sample_en = 1'b1; node_in = 1'b1;
    pattern = '1; pat_mask = '0; result_ready = 1'b0;

    // Reset dominates a concurrent start.
    step();
    step();
    chk("rst.busy",  32'(busy),         32'd0);
    chk("rst.valid", 32'(result_valid), 32'd0);
    check_result("rst", '{32'd0, 32'd0, 1'b0, 1'b0});
    rst = 1'b0; start = 1'b0; sample_en = 1'b0; node_in = 1'b0;
    step();
    chk("idle.busy", 32'(busy), 32'd0);

    // Table of full windows.
    for (int v = 0; v < int'(NV); v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_window(tag, vecs[v].stream, vecs[v].pat, vecs[v].mask);
      check_result(tag, vecs[v].exp);
      handshake(tag, vecs[v].exp);
      step();
    end

    // Result held under backpressure; inputs and start ignored in REPORT.
    e = '{32'd0, 32'd8, 1'b1, 1'b1};
    run_window("hold", 8'hFF, 4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      sample_en = 1'b1;
      node_in   = c[0];
      start     = 1'b1;
      step();
      chk($sformatf("hold%0d.valid", c), 32'(result_valid), 32'd1);
      check_result($sformatf("hold%0d", c), e);
    end
    sample_en = 1'b0;
    // start together with the handshake is dropped.
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("hold.valid_off", 32'(result_valid), 32'd0);
    chk("hold.busy_off",  32'(busy),         32'd0);
    step();
    chk("hold.no_queue", 32'(busy), 32'd0);

    // 50% gated sample_en; 8th enabled sample lands on the 16th cycle.
    pattern = 4'b0110; pat_mask = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      logic [7:0] s;
      s = 8'b10101010;
      for (int c = 0; c < 16; c++) begin
        sample_en = c[0];
        node_in   = c[0] ? s[7 - c/2] : ~s[7 - c/2];
        start     = (c == 4);
        if (c == 15) chk("gate.valid_early", 32'(result_valid), 32'd0);
        step();
      end
    end
    sample_en = 1'b0; start = 1'b0;
    chk("gate.valid", 32'(result_valid), 32'd1);
    check_result("gate", '{32'd7, 32'd4, 1'b0, 1'b0});
    handshake("gate", '{32'd7, 32'd4, 1'b0, 1'b0});

    // Reset mid-window, then a clean window.
    pattern = 4'b0000; pat_mask = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      logic [4:0] s5;
      s5 = 5'b10110;
      for (int i = 0; i < 5; i++) begin
        sample_en = 1'b1;
        node_in   = s5[4-i];
        step();
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample_en = 1'b0;
    chk("midrst.busy",  32'(busy),         32'd0);
    chk("midrst.valid", 32'(result_valid), 32'd0);
    check_result("midrst", '{32'd0, 32'd0, 1'b0, 1'b0});
    step();
    chk("midrst.idle", 32'(busy), 32'd0);
    run_window("after_rst", 8'b10101010, 4'b0110, 4'b1111);
    check_result("after_rst", '{32'd7, 32'd4, 1'b0, 1'b0});
    handshake("after_rst", '{32'd7, 32'd4, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nt_node_activity_monitor.md
Name: nt_node_activity_monitor

Overview:
- Downstream observation stage for one Nt-node subcircuit output net.
- Samples the 1-bit net over a fixed window and counts toggles and ones.
- Detects a programmable masked bit pattern and flags rare-activity nets as trojan-trigger candidates.
- Reports one result per window through a valid/ready handshake to the detection collector.

Parameters:
- WINDOW, 256, number of enabled samples per measurement window (>=2).
- RARE_THRESH, 2, toggle count strictly below this sets rare_flag.
- PAT_LEN, 8, length of the pattern shift register (1..32).
- CNT_W, $clog2(WINDOW+1), counter width (derived, not overridden).

Ports:
- I1470  input  1  clock; all state updates on rising edge.
- I1477  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse that begins a window; honoured only in IDLE.
- sample_en  input  1  qualifies node_in; only enabled cycles are counted.
- node_in  input  1  monitored subcircuit output net.
- pattern  input  PAT_LEN  target sequence; bit 0 is the newest sample; captured at start.
- pat_mask  input  PAT_LEN  1 = bit compared; captured at start.
- busy  output  1  high in SAMPLE and REPORT.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- toggle_count  output  CNT_W  transitions between consecutive enabled samples.
- ones_count  output  CNT_W  enabled samples equal to 1.
- match_flag  output  1  masked pattern matched at least once in the window.
- rare_flag  output  1  rare-activity verdict.

Behaviour:
- Reset (I1477=1 at an edge):
  - State goes to IDLE.
  - All outputs, counters, shift register, captured pattern/mask and prev-sample register clear to 0.
  - Takes priority over every other event, including mid-window and mid-handshake; no partial result is emitted.
- FSM IDLE:
  - start=1 captures pattern/mask, clears counters, sample index and shift register, then goes to SAMPLE.
  - busy=0.
- FSM SAMPLE, each cycle with sample_en=1:
  - Shift node_in into the shift register.
  - ones_count += node_in.
  - If sample index > 0 and node_in != prev: toggle_count += 1.
  - prev <= node_in; index += 1.
  - Cycles with sample_en=0 change nothing.
- Pattern match:
  - Evaluated on the post-shift register once at least PAT_LEN samples are taken in the window.
  - Matches when ((shreg ^ pattern) & pat_mask) == 0.
  - Sets sticky match_flag for the window.
  - pat_mask=0 matches at sample PAT_LEN.
- Window end:
  - The enabled sample making index == WINDOW is counted.
  - Next cycle: state REPORT, result_valid=1.
  - rare_flag = (toggle_count < RARE_THRESH) | (ones_count == 0) | (ones_count == WINDOW).
- FSM REPORT:
  - Outputs hold stable while result_valid=1 and result_ready=0.
  - On result_valid & result_ready: result_valid falls next cycle and state returns to IDLE.
  - Outputs keep their last values until the next start.
  - node_in and sample_en are ignored.
- start while busy is ignored and never queued.
- start in the same cycle as the handshake is ignored; IDLE is entered first.
- Counters cannot exceed WINDOW, so no wrap is possible. An assertion checks that toggle_count <= WINDOW-1.
- Latency: result_valid rises exactly 1 cycle after the WINDOW-th enabled sample.

Decomposition:
- Shared package nt_mon_pkg holds:
  - state enum {IDLE, SAMPLE, REPORT};
  - result struct {toggle_count, ones_count, match_flag, rare_flag};
  - the CNT_W derivation function.
- One sub-module, nt_pattern_matcher: PAT_LEN shift register, masked compare and sticky match bit, with clear/shift/enable inputs.
- Counters and FSM stay in the top module.

Test Plan:
- Reset then idle: all outputs 0 and busy=0; start while I1477=1 leaves state IDLE.
- WINDOW=8, sample_en=1, node_in=10101010 → toggle_count=7, ones_count=4, rare_flag=0; result_valid rises 1 cycle after the 8th sample.
- WINDOW=8, node_in constant 1 → toggle_count=0, ones_count=8, rare_flag=1; result held for 5 cycles with result_ready=0 and unchanged, then cleared on ready.
- PAT_LEN=4, pattern=4'b0110, mask=4'b1111, stream 0,0,1,1,0,0 → match_flag=1. The same stream with pattern 4'b1001 → match_flag=0.
- sample_en gated 50% and WINDOW=8 → window closes after the 8th enabled sample (cycle 16); a start pulsed mid-window is ignored.
- Reset asserted at sample 5 → next cycle IDLE and counts 0; a new start then completes a full 8-sample window normally.
